alu_arbiter: RTL and testbench

- Shares one 64-bit integer ALU between NUM_REQ requesters (one per core in the multicore build).
- Round-robin arbitration, operand capture, a fixed 3-state sequence, and a registered result returned to the winning requester with a one-cycle done pulse.
- Sits between the per-core execute stages and a single instance of the existing alu module.

---
 rtl/alu_defs.sv | 21 ++
 rtl/alu.sv | 34 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared opcode and state encodings for the shared-ALU arbiter and its datapath.
package alu_defs;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; opcodes 10..15 yield zero, NOP yields a marker pattern.
module alu
  import alu_defs::*;
#(
  parameter int unsigned DATAPATH_WIDTH = 64
) (
  input  logic [DATAPATH_WIDTH-1:0] a_in,
  input  logic [DATAPATH_WIDTH-1:0] b_in,
  input  logic [3:0]                ctrl_in,
  input  logic [4:0]                shift_in,
  output logic [DATAPATH_WIDTH-1:0] accum_out,
  output logic                      zero_out
);

  always_comb begin
    accum_out = '0;
    case (ctrl_in)
      ALU_NOP:  accum_out = {(DATAPATH_WIDTH / 16){16'hdeaf}};
      ALU_ADD:  accum_out = a_in + b_in;
      ALU_SUB:  accum_out = a_in - b_in;
      ALU_AND:  accum_out = a_in & b_in;
      ALU_OR:   accum_out = a_in | b_in;
      ALU_NOT:  accum_out = ~a_in;
      ALU_XOR:  accum_out = a_in ^ b_in;
      ALU_SLTU: accum_out = {{(DATAPATH_WIDTH - 1){1'b0}}, (a_in < b_in)};
      ALU_SLL:  accum_out = a_in << shift_in;
      ALU_SRL:  accum_out = a_in >> shift_in;
      default:  accum_out = '0;
    endcase
  end

  assign zero_out = (accum_out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters; IDLE -> EXEC -> DONE per op.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int unsigned DATAPATH_WIDTH = 64,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_in,
  input  logic [NUM_REQ*DATAPATH_WIDTH-1:0] a_in,
  input  logic [NUM_REQ*DATAPATH_WIDTH-1:0] b_in,
  input  logic [NUM_REQ*4-1:0]              ctrl_in,
  input  logic [NUM_REQ*5-1:0]              shift_in,
  output logic [NUM_REQ-1:0]                grant_out,
  output logic [NUM_REQ-1:0]                done_out,
  output logic [DATAPATH_WIDTH-1:0]         result_out,
  output logic                              zero_out,
  output logic [ID_W-1:0]                   winner_out,
  output logic                              busy_out
);

  // Lowest offset from the pointer wins, so scan offsets high-to-low and keep the last hit.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    int unsigned     j;
    rr_pick = ptr;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      j   = (32'(ptr) + k - 1) % NUM_REQ;
      idx = j[ID_W-1:0];
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  state_t                    r_state, w_state;
  logic [NUM_REQ-1:0]        r_grant, w_grant;
  logic [NUM_REQ-1:0]        r_done, w_done;
  logic [DATAPATH_WIDTH-1:0] r_result, w_result;
  logic                      r_zero, w_zero;
  logic [ID_W-1:0]           r_winner, w_winner;
  logic [ID_W-1:0]           r_ptr, w_ptr;
  logic [DATAPATH_WIDTH-1:0] r_a, w_a;
  logic [DATAPATH_WIDTH-1:0] r_b, w_b;
  logic [3:0]                r_ctrl, w_ctrl;
  logic [4:0]                r_shift, w_shift;

  logic [ID_W-1:0]           w_win;
  logic [DATAPATH_WIDTH-1:0] w_accum;
  logic                      w_accum_zero;

  assign w_win = rr_pick(req_in, r_ptr);

  alu #(
    .DATAPATH_WIDTH(DATAPATH_WIDTH)
  ) u_alu (
    .a_in     (r_a),
    .b_in     (r_b),
    .ctrl_in  (r_ctrl),
    .shift_in (r_shift),
    .accum_out(w_accum),
    .zero_out (w_accum_zero)
  );

  always_comb begin
    w_state  = r_state;
    w_grant  = r_grant;
    w_done   = r_done;
    w_result = r_result;
    w_zero   = r_zero;
    w_winner = r_winner;
    w_ptr    = r_ptr;
    w_a      = r_a;
    w_b      = r_b;
    w_ctrl   = r_ctrl;
    w_shift  = r_shift;
    unique case (r_state)
      IDLE: begin
        w_grant = '0;
        if (|req_in) begin
          w_a      = a_in[w_win*DATAPATH_WIDTH +: DATAPATH_WIDTH];
          w_b      = b_in[w_win*DATAPATH_WIDTH +: DATAPATH_WIDTH];
          w_ctrl   = ctrl_in[w_win*4 +: 4];
          w_shift  = shift_in[w_win*5 +: 5];
          w_grant  = {{(NUM_REQ - 1){1'b0}}, 1'b1} << w_win;
          w_winner = w_win;
          w_ptr    = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
          w_state  = EXEC;
        end
      end
      EXEC: begin
        w_result = w_accum;
        w_zero   = w_accum_zero;
        w_done   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << r_winner;
        w_state  = DONE;
      end
      DONE: begin
        w_done  = '0;
        w_grant = '0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_winner <= '0;
      r_ptr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_ctrl   <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state;
      r_grant  <= w_grant;
      r_done   <= w_done;
      r_result <= w_result;
      r_zero   <= w_zero;
      r_winner <= w_winner;
      r_ptr    <= w_ptr;
      r_a      <= w_a;
      r_b      <= w_b;
      r_ctrl   <= w_ctrl;
      r_shift  <= w_shift;
    end
  end

  assign grant_out  = r_grant;
  assign done_out   = r_done;
  assign result_out = r_result;
  assign zero_out   = r_zero;
  assign winner_out = r_winner;
  assign busy_out   = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor pops on each done pulse.
module tb_alu_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req_in = '0;
  logic [NR*DW-1:0] a_in = '0;
  logic [NR*DW-1:0] b_in = '0;
  logic [NR*4-1:0] ctrl_in = '0;
  logic [NR*5-1:0] shift_in = '0;
  logic [NR-1:0]   grant_out;
  logic [NR-1:0]   done_out;
  logic [DW-1:0]   result_out;
  logic            zero_out;
  logic [1:0]      winner_out;
  logic            busy_out;

  typedef struct {
    logic [NR-1:0] done;
    logic [DW-1:0] res;
    logic          zero;
    logic [1:0]    win;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  alu_arbiter #(
    .DATAPATH_WIDTH(DW),
    .NUM_REQ       (NR),
    .ID_W          (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_in    (req_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .ctrl_in   (ctrl_in),
    .shift_in  (shift_in),
    .grant_out (grant_out),
    .done_out  (done_out),
    .result_out(result_out),
    .zero_out  (zero_out),
    .winner_out(winner_out),
    .busy_out  (busy_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_out != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done_out), 64'd0);
      end else begin
        e = q.pop_front();
        chk("done_out", 64'(done_out), 64'(e.done));
        chk("result_out", result_out, e.res);
        chk("zero_out", 64'(zero_out), 64'(e.zero));
        chk("winner_out", 64'(winner_out), 64'(e.win));
      end
    end
  end

  task automatic push_exp(input int id, input logic [DW-1:0] res, input logic zero);
    exp_t e;
    e.done = NR'(1) << id;
    e.res  = res;
    e.zero = zero;
    e.win  = 2'(id);
    q.push_back(e);
  endtask

  task automatic set_ops(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [3:0] ctrl, input logic [4:0] sh);
    a_in[id*DW +: DW]    = a;
    b_in[id*DW +: DW]    = b;
    ctrl_in[id*4 +: 4]   = ctrl;
    shift_in[id*5 +: 5]  = sh;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_in  = '0;
    @(negedge clk);
    chk("rst_grant", 64'(grant_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_result", result_out, 64'd0);
    chk("rst_zero", 64'(zero_out), 64'd0);
    chk("rst_winner", 64'(winner_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input int id, input string name);
    int k;
    k = 0;
    while (!done_out[id] && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!done_out[id]) chk({name, "_timeout"}, 64'(done_out), 64'(NR'(1) << id));
  endtask

  // Single requester op; optionally clobbers operand A once the op is in flight.
  task automatic do_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] ctrl, input logic [4:0] sh,
                       input logic [DW-1:0] exp_res, input logic exp_zero, input bit mangle);
    @(negedge clk);
    set_ops(id, a, b, ctrl, sh);
    push_exp(id, exp_res, exp_zero);
    req_in[id] = 1'b1;
    @(negedge clk);
    chk("grant_out", 64'(grant_out), 64'(NR'(1) << id));
    chk("busy_exec", 64'(busy_out), 64'd1);
    if (mangle) a_in[id*DW +: DW] = '0;
    @(negedge clk);
    chk("done_latency", 64'(done_out), 64'(NR'(1) << id));
    wait_done(id, "op");
    req_in[id] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int last;
    int id;
    do_reset();

    // Single op: 5 + 7.
    do_op(0, 64'd5, 64'd7, 4'd1, 5'd0, 64'd12, 1'b0, 1'b0);

    // Fairness from a freshly reset pointer.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_ops(i, 64'(i + 1), 64'd10, 4'd1, 5'd0);
    push_exp(0, 64'd11, 1'b0);
    push_exp(1, 64'd12, 1'b0);
    push_exp(2, 64'd13, 1'b0);
    push_exp(3, 64'd14, 1'b0);
    push_exp(0, 64'd11, 1'b0);
    req_in = 4'b1111;
    last = 0;
    for (int n = 0; n < 5; n++) begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (done_out == '0 && k < 10);
      if (done_out == '0) begin
        chk("fair_timeout", 64'd0, 64'd1);
        break;
      end
      id = 0;
      for (int b = 0; b < NR; b++) if (done_out[b]) id = b;
      if (n > 0) chk("fair_spacing", 64'(cyc - last), 64'd3);
      last = cyc;
      if (n == 4) begin
        req_in = '0;
      end else begin
        req_in[id] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req_in[id] = 1'b1;
      end
    end

    // Wrap-around to zero, then borrow to all ones.
    do_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd1, 5'd0, 64'd0, 1'b1, 1'b0);
    do_op(2, 64'd0, 64'd1, 4'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // Operand A cleared after grant must not disturb 1 << 4.
    do_op(1, 64'd1, 64'd0, 4'd8, 5'd4, 64'd16, 1'b0, 1'b1);

    // NOP marker, reserved opcode, unsigned compare, logical right shift.
    do_op(0, 64'd3, 64'd4, 4'd0, 5'd0, 64'hdeaf_deaf_deaf_deaf, 1'b0, 1'b0);
    do_op(0, 64'd3, 64'd4, 4'd12, 5'd0, 64'd0, 1'b1, 1'b0);
    do_op(3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 5'd0, 64'd1, 1'b0, 1'b0);
    do_op(3, 64'h8000_0000_0000_0000, 64'd0, 4'd9, 5'd31, 64'h0000_0001_0000_0000, 1'b0, 1'b0);

    // Reset mid-op: requester 1 wins (pointer -> 2), reset lands in EXEC.
    @(negedge clk);
    set_ops(1, 64'd2, 64'd3, 4'd1, 5'd0);
    set_ops(3, 64'd9, 64'd9, 4'd1, 5'd0);
    req_in = 4'b0010;
    @(negedge clk);
    chk("pre_rst_grant", 64'(grant_out), 64'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_grant", 64'(grant_out), 64'd0);
    chk("async_result", result_out, 64'd0);
    chk("async_zero", 64'(zero_out), 64'd0);
    chk("async_winner", 64'(winner_out), 64'd0);
    chk("async_busy", 64'(busy_out), 64'd0);
    req_in = 4'b1010;
    @(negedge clk);
    chk("rst_hold_done", 64'(done_out), 64'd0);
    // Pointer back at 0 means requester 1 beats requester 3.
    push_exp(1, 64'd5, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(grant_out), 64'b0010);
    wait_done(1, "post_rst");
    req_in = '0;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
